anubis_dec_key_buffer: RTL and testbench

Stores the ROUNDS+1 encryption round keys produced by key_selection during a forward key-schedule pass. Replays them in reverse order as Anubis decryption round keys. Per the Anubis decryption schedule: K'0 = K_R, K'r = theta(K_{R-r}) for 0<r<R, and K'R = K0. The block sits between key_selection (write side) and the round datapath when the core runs in decrypt mode.

---
 rtl/anubis_dec_key_buffer.sv | 162 ++++++++++++++++
 tb/tb_anubis_dec_key_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/anubis_dec_key_buffer.sv
// Anubis decryption key buffer: captures the forward key schedule,
// replays it in reverse order with theta applied to the inner keys.
module anubis_dec_key_buffer #(
  parameter int ROUNDS = 12,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [127:0]     wr_key,
  input  logic             rd_start,
  input  logic             rd_next,
  output logic [127:0]     rd_key,
  output logic             rd_valid,
  output logic [IDX_W-1:0] rd_round,
  output logic             full,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE, FILL, READY, DRAIN
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
  endfunction

  // p[k][e] holds a[i][k] * h[e] for h = {01,02,04,06}
  function automatic logic [127:0] theta(input logic [127:0] a);
    logic [127:0] b;
    logic [7:0]   p [4][4];
    logic [7:0]   acc;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        p[k][0] = a[127-8*(4*i+k) -: 8];
        p[k][1] = xt(p[k][0]);
        p[k][2] = xt(p[k][1]);
        p[k][3] = p[k][2] ^ p[k][1];
      end
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ p[k][k^j];
        b[127-8*(4*i+j) -: 8] = acc;
      end
    end
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] rd_round_q, rd_round_d;
  logic [127:0]     rd_key_q, rd_key_d;
  logic             rd_valid_q, rd_valid_d;
  logic             full_q, full_d;
  logic [127:0]     keys_q [ROUNDS+1];

  logic             we;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] nidx;
  logic [127:0]     nkey;
  logic [127:0]     nkey_x;

  // Both READY->DRAIN and each advance load the key at nidx
  assign nidx   = (state_q == READY) ? LAST : rd_ptr_q - 1'b1;
  assign nkey   = keys_q[nidx];
  assign nkey_x = (nidx == LAST || nidx == '0) ? nkey
                                               : theta(nkey);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_round_d = rd_round_q;
    rd_key_d   = rd_key_q;
    rd_valid_d = rd_valid_q;
    full_d     = full_q;
    we         = 1'b0;
    widx       = wr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (wr_valid) begin
          we       = 1'b1;
          widx     = '0;
          wr_ptr_d = IDX_W'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        if (wr_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST) begin
            state_d = READY;
            full_d  = 1'b1;
          end
        end
      end
      READY: begin
        if (rd_start) begin
          state_d    = DRAIN;
          rd_ptr_d   = LAST;
          rd_key_d   = nkey_x;
          rd_valid_d = 1'b1;
          rd_round_d = '0;
        end
      end
      DRAIN: begin
        if (rd_next && rd_valid_q) begin
          if (rd_round_q == LAST) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
            full_d     = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_round_d = '0;
          end else begin
            rd_ptr_d   = nidx;
            rd_round_d = rd_round_q + 1'b1;
            rd_key_d   = nkey_x;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_round_q <= '0;
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_round_q <= rd_round_d;
      rd_key_q   <= rd_key_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) keys_q[widx] <= wr_key;
  end

  assign rd_key   = rd_key_q;
  assign rd_valid = rd_valid_q;
  assign rd_round = rd_round_q;
  assign full     = full_q;
  assign busy     = (state_q == FILL) || (state_q == DRAIN);

endmodule

// File: tb/tb_anubis_dec_key_buffer.sv
// Bench for anubis_dec_key_buffer: fills, replays and checks the
// reversed decryption key stream through a scoreboard queue.
module tb_anubis_dec_key_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid;
  logic [127:0] wr_key;
  logic         rd_start;
  logic         rd_next;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic [3:0]   rd_round;
  logic         full;
  logic         busy;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   round;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  anubis_dec_key_buffer #(.ROUNDS(12), .IDX_W(4)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_key(wr_key),
    .rd_start(rd_start), .rd_next(rd_next),
    .rd_key(rd_key), .rd_valid(rd_valid),
    .rd_round(rd_round), .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      b = b >> 1;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1d) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_theta(input logic [127:0] a);
    logic [7:0]   h [4] = '{8'h01, 8'h02, 8'h04, 8'h06};
    logic [127:0] r = '0;
    logic [7:0]   acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gm(a[127-8*(4*i+k) -: 8], h[k^j]);
        r[127-8*(4*i+j) -: 8] = acc;
      end
    return r;
  endfunction

  // pattern 0: K_r = r in byte 15; pattern 1: K_r = r in byte 0
  function automatic logic [127:0] key_of(input int pat, input int idx);
    logic [7:0] v = 8'(idx);
    return (pat == 0) ? {120'b0, v} : {v, 120'b0};
  endfunction

  task automatic push_all(input int pat);
    exp_t e;
    int   idx;
    for (int r = 0; r <= 12; r++) begin
      idx = 12 - r;
      e.round = 4'(r);
      if (idx == 12 || idx == 0) e.key = key_of(pat, idx);
      else e.key = ref_theta(key_of(pat, idx));
      if (pat == 0 && r == 1)
        e.key = 128'h00000000_00000000_00000000_3a2c160b;
      if (pat == 1 && r == 11)
        e.key = 128'h01020406_00000000_00000000_00000000;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_key: got round %0d key %h, want none",
                 rd_round, rd_key);
      end else begin
        chk("rd_key", rd_key, exp_q[0].key);
        chk("rd_round", 128'(rd_round), 128'(exp_q[0].round));
        if (rd_next) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 128'(rd_valid), 128'(0));
    chk({nm, "_round"}, 128'(rd_round), 128'(0));
    chk({nm, "_full"},  128'(full), 128'(0));
    chk({nm, "_busy"},  128'(busy), 128'(0));
  endtask

  task automatic fill(input int pat, input bit noise);
    for (int idx = 0; idx <= 12; idx++) begin
      wr_valid = 1'b1;
      wr_key   = key_of(pat, idx);
      rd_start = noise && (idx >= 11);
      if (idx == 12) begin
        chk("fill_full", 128'(full), 128'(0));
        chk("fill_busy", 128'(busy), 128'(1));
      end
      tick();
    end
    wr_valid = 1'b0;
    rd_start = 1'b0;
    chk("ready_full", 128'(full), 128'(1));
    chk("ready_busy", 128'(busy), 128'(0));
    chk("ready_valid", 128'(rd_valid), 128'(0));
    wr_valid = 1'b1;
    wr_key   = {128{1'b1}};
    tick();
    tick();
    wr_valid = 1'b0;
    chk("junk_ready_valid", 128'(rd_valid), 128'(0));
  endtask

  task automatic start;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("start_valid", 128'(rd_valid), 128'(1));
    chk("start_busy", 128'(busy), 128'(1));
    chk("start_full", 128'(full), 128'(1));
  endtask

  task automatic drain(input int n_adv);
    for (int i = 0; i < n_adv; i++) begin
      rd_next  = 1'b1;
      wr_valid = 1'b1;
      wr_key   = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
      rd_start = 1'b1;
      tick();
      rd_next  = 1'b0;
      wr_valid = 1'b0;
      rd_start = 1'b0;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    wr_valid = 1'b0;
    wr_key = '0;
    rd_start = 1'b0;
    rd_next = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_idle("reset");
    chk("reset_key", rd_key, 128'h0);

    fill(0, 1'b1);
    push_all(0);
    start();
    drain(13);
    chk_idle("done0");
    chk("done0_key", rd_key, key_of(0, 0));
    chk("done0_q", 128'(exp_q.size()), 128'(0));

    fill(1, 1'b0);
    push_all(1);
    start();
    drain(5);
    chk("mid_round", 128'(rd_round), 128'(5));
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk_idle("midrst");
    chk("midrst_key", rd_key, 128'h0);

    fill(1, 1'b1);
    push_all(1);
    start();
    drain(13);
    chk_idle("done1");
    chk("done1_q", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
